// File: rtl/pcie_cfg_tlp_trans.sv
// rtl/pcie_cfg_tlp_trans.sv - config request to CfgRd/CfgWr TLP generator and completion matcher
// Optional completion timeout is enabled by defining PCIE_CFG_CPL_TIMEOUT_EN.
module pcie_cfg_tlp_trans #(
  parameter int CPL_TIMEOUT_CYCLES = 65535
) (
  input  logic        pclk_div2,
  input  logic        apb_rst_n,
  input  logic        pcie_cfg_ctrl_en,
  input  logic        pcie_cfg_fmt,
  input  logic        pcie_cfg_type,
  input  logic [7:0]  pcie_cfg_tag,
  input  logic [3:0]  pcie_cfg_fbe,
  input  logic [15:0] pcie_cfg_req_id,
  input  logic [15:0] pcie_cfg_des_id,
  input  logic [9:0]  pcie_cfg_reg_num,
  input  logic [31:0] pcie_cfg_tx_data,
  input  logic        tx_en,
  output logic        pcie_cfg_cpl_rcv,
  output logic [2:0]  pcie_cfg_cpl_status,
  output logic [31:0] pcie_cfg_rx_data,
  output logic        cfg_busy,
  output logic        cfg_tlp_tx_valid,
  input  logic        cfg_tlp_tx_ready,
  output logic [31:0] cfg_tlp_tx_data,
  output logic        cfg_tlp_tx_sop,
  output logic        cfg_tlp_tx_eop,
  input  logic        cfg_tlp_rx_valid,
  input  logic [31:0] cfg_tlp_rx_data,
  input  logic        cfg_tlp_rx_sop,
  input  logic        cfg_tlp_rx_eop
);

  typedef enum logic [2:0] {IDLE, TX_H0, TX_H1, TX_H2, TX_D, WAIT_CPL} state_t;
  state_t state_q, state_d;

  logic        tx_en_d;
  logic        fmt_q, type_q, abort_q;
  logic [7:0]  tag_q;
  logic [3:0]  fbe_q;
  logic [15:0] req_id_q, des_id_q;
  logic [9:0]  reg_num_q;
  logic [31:0] tx_data_q;

  logic        rx_live_q, rx_is_cpl_q, rx_is_cpld_q, rx_wait_q, rx_match_q;
  logic [1:0]  rx_beat_q;
  logic [2:0]  rx_status_q;

  logic        accept, in_tx, tx_hs, stop_after_tlp;
  logic        hdr_match, fire_match, timeout_fire;
  logic [31:0] fire_data;

  assign accept         = (state_q == IDLE) && pcie_cfg_ctrl_en && tx_en && !tx_en_d;
  assign in_tx          = (state_q == TX_H0) || (state_q == TX_H1) ||
                          (state_q == TX_H2) || (state_q == TX_D);
  assign tx_hs          = cfg_tlp_tx_valid && cfg_tlp_tx_ready;
  assign stop_after_tlp = abort_q || !pcie_cfg_ctrl_en;
  assign cfg_busy       = (state_q != IDLE);

  always_comb begin
    cfg_tlp_tx_valid = in_tx;
    cfg_tlp_tx_sop   = (state_q == TX_H0);
    cfg_tlp_tx_eop   = ((state_q == TX_H2) && !fmt_q) || (state_q == TX_D);
    cfg_tlp_tx_data  = 32'd0;
    case (state_q)
      TX_H0:   cfg_tlp_tx_data = {(fmt_q ? 3'b010 : 3'b000), 4'b0010, type_q, 14'd0, 10'd1};
      TX_H1:   cfg_tlp_tx_data = {req_id_q, tag_q, 4'b0000, fbe_q};
      TX_H2:   cfg_tlp_tx_data = {des_id_q, 4'b0000, reg_num_q[9:6], reg_num_q[5:0], 2'b00};
      TX_D:    cfg_tlp_tx_data = tx_data_q;
      default: cfg_tlp_tx_data = 32'd0;
    endcase
  end

  // A completion only counts if it both started and finished while we were waiting.
  assign hdr_match = rx_is_cpl_q && rx_wait_q && (state_q == WAIT_CPL) &&
                     (cfg_tlp_rx_data[31:16] == req_id_q) && (cfg_tlp_rx_data[15:8] == tag_q);

  always_comb begin
    fire_match = 1'b0;
    fire_data  = 32'd0;
    if (cfg_tlp_rx_valid && !cfg_tlp_rx_sop && rx_live_q) begin
      if ((rx_beat_q == 2'd2) && !rx_is_cpld_q && hdr_match) begin
        fire_match = 1'b1;
      end else if ((rx_beat_q == 2'd3) && rx_is_cpld_q && rx_match_q && (state_q == WAIT_CPL)) begin
        fire_match = 1'b1;
        fire_data  = cfg_tlp_rx_data;
      end
    end
  end

`ifdef PCIE_CFG_CPL_TIMEOUT_EN
  localparam int CW = $clog2(CPL_TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;

  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n)                to_cnt_q <= '0;
    else if (state_q != WAIT_CPL)  to_cnt_q <= '0;
    else                           to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout_fire = (state_q == WAIT_CPL) && pcie_cfg_ctrl_en && !fire_match &&
                        (to_cnt_q == CW'(CPL_TIMEOUT_CYCLES - 1));
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = TX_H0;
      TX_H0:    if (tx_hs) state_d = TX_H1;
      TX_H1:    if (tx_hs) state_d = TX_H2;
      TX_H2:    if (tx_hs) state_d = fmt_q ? TX_D : (stop_after_tlp ? IDLE : WAIT_CPL);
      TX_D:     if (tx_hs) state_d = stop_after_tlp ? IDLE : WAIT_CPL;
      WAIT_CPL: if (fire_match || timeout_fire || !pcie_cfg_ctrl_en) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state_q   <= IDLE;
      tx_en_d   <= 1'b0;
      abort_q   <= 1'b0;
      fmt_q     <= 1'b0;
      type_q    <= 1'b0;
      tag_q     <= 8'd0;
      fbe_q     <= 4'd0;
      req_id_q  <= 16'd0;
      des_id_q  <= 16'd0;
      reg_num_q <= 10'd0;
      tx_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      tx_en_d <= tx_en;
      if (state_q == IDLE)                abort_q <= 1'b0;
      else if (in_tx && !pcie_cfg_ctrl_en) abort_q <= 1'b1;
      if (accept) begin
        fmt_q     <= pcie_cfg_fmt;
        type_q    <= pcie_cfg_type;
        tag_q     <= pcie_cfg_tag;
        fbe_q     <= pcie_cfg_fbe;
        req_id_q  <= pcie_cfg_req_id;
        des_id_q  <= pcie_cfg_des_id;
        reg_num_q <= pcie_cfg_reg_num;
        tx_data_q <= pcie_cfg_tx_data;
      end
    end
  end

  // Parser restarts on every sop so a truncated TLP can never poison the next one.
  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      rx_live_q    <= 1'b0;
      rx_beat_q    <= 2'd0;
      rx_is_cpl_q  <= 1'b0;
      rx_is_cpld_q <= 1'b0;
      rx_wait_q    <= 1'b0;
      rx_match_q   <= 1'b0;
      rx_status_q  <= 3'd0;
    end else if (cfg_tlp_rx_valid) begin
      if (cfg_tlp_rx_sop) begin
        rx_live_q    <= !cfg_tlp_rx_eop;
        rx_beat_q    <= 2'd1;
        rx_is_cpl_q  <= (cfg_tlp_rx_data[28:24] == 5'b01010) &&
                        ((cfg_tlp_rx_data[31:29] == 3'b000) || (cfg_tlp_rx_data[31:29] == 3'b010));
        rx_is_cpld_q <= (cfg_tlp_rx_data[28:24] == 5'b01010) && (cfg_tlp_rx_data[31:29] == 3'b010);
        rx_wait_q    <= (state_q == WAIT_CPL);
        rx_match_q   <= 1'b0;
      end else if (rx_live_q) begin
        case (rx_beat_q)
          2'd1: begin
            rx_status_q <= cfg_tlp_rx_data[15:13];
            rx_beat_q   <= 2'd2;
          end
          2'd2: begin
            rx_match_q <= hdr_match;
            rx_beat_q  <= 2'd3;
            if (!rx_is_cpld_q) rx_live_q <= 1'b0;
          end
          default: rx_live_q <= 1'b0;
        endcase
        if (cfg_tlp_rx_eop) rx_live_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      pcie_cfg_cpl_rcv    <= 1'b0;
      pcie_cfg_cpl_status <= 3'd0;
      pcie_cfg_rx_data    <= 32'd0;
    end else begin
      pcie_cfg_cpl_rcv <= fire_match || timeout_fire;
      if (fire_match) begin
        pcie_cfg_cpl_status <= rx_status_q;
        pcie_cfg_rx_data    <= fire_data;
      end else if (timeout_fire) begin
        pcie_cfg_cpl_status <= 3'b111;
        pcie_cfg_rx_data    <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_cfg_tlp_trans.sv
// tb/tb_pcie_cfg_tlp_trans.sv - self-checking bench for pcie_cfg_tlp_trans
module tb_pcie_cfg_tlp_trans;

  logic        pclk_div2 = 1'b0;
  logic        apb_rst_n = 1'b0;
  logic        pcie_cfg_ctrl_en = 1'b1;
  logic        pcie_cfg_fmt = 1'b0;
  logic        pcie_cfg_type = 1'b0;
  logic [7:0]  pcie_cfg_tag = 8'd0;
  logic [3:0]  pcie_cfg_fbe = 4'd0;
  logic [15:0] pcie_cfg_req_id = 16'd0;
  logic [15:0] pcie_cfg_des_id = 16'd0;
  logic [9:0]  pcie_cfg_reg_num = 10'd0;
  logic [31:0] pcie_cfg_tx_data = 32'd0;
  logic        tx_en = 1'b0;
  logic        pcie_cfg_cpl_rcv;
  logic [2:0]  pcie_cfg_cpl_status;
  logic [31:0] pcie_cfg_rx_data;
  logic        cfg_busy;
  logic        cfg_tlp_tx_valid;
  logic        cfg_tlp_tx_ready = 1'b1;
  logic [31:0] cfg_tlp_tx_data;
  logic        cfg_tlp_tx_sop;
  logic        cfg_tlp_tx_eop;
  logic        cfg_tlp_rx_valid = 1'b0;
  logic [31:0] cfg_tlp_rx_data = 32'd0;
  logic        cfg_tlp_rx_sop = 1'b0;
  logic        cfg_tlp_rx_eop = 1'b0;

  pcie_cfg_tlp_trans #(.CPL_TIMEOUT_CYCLES(16)) dut (
    .pclk_div2(pclk_div2), .apb_rst_n(apb_rst_n),
    .pcie_cfg_ctrl_en(pcie_cfg_ctrl_en), .pcie_cfg_fmt(pcie_cfg_fmt),
    .pcie_cfg_type(pcie_cfg_type), .pcie_cfg_tag(pcie_cfg_tag),
    .pcie_cfg_fbe(pcie_cfg_fbe), .pcie_cfg_req_id(pcie_cfg_req_id),
    .pcie_cfg_des_id(pcie_cfg_des_id), .pcie_cfg_reg_num(pcie_cfg_reg_num),
    .pcie_cfg_tx_data(pcie_cfg_tx_data), .tx_en(tx_en),
    .pcie_cfg_cpl_rcv(pcie_cfg_cpl_rcv), .pcie_cfg_cpl_status(pcie_cfg_cpl_status),
    .pcie_cfg_rx_data(pcie_cfg_rx_data), .cfg_busy(cfg_busy),
    .cfg_tlp_tx_valid(cfg_tlp_tx_valid), .cfg_tlp_tx_ready(cfg_tlp_tx_ready),
    .cfg_tlp_tx_data(cfg_tlp_tx_data), .cfg_tlp_tx_sop(cfg_tlp_tx_sop),
    .cfg_tlp_tx_eop(cfg_tlp_tx_eop), .cfg_tlp_rx_valid(cfg_tlp_rx_valid),
    .cfg_tlp_rx_data(cfg_tlp_rx_data), .cfg_tlp_rx_sop(cfg_tlp_rx_sop),
    .cfg_tlp_rx_eop(cfg_tlp_rx_eop)
  );

  always #5 pclk_div2 = ~pclk_div2;

  typedef struct {
    logic             fmt;
    logic             typ;
    logic [7:0]       tag;
    logic [3:0]       fbe;
    logic [15:0]      req_id;
    logic [15:0]      des_id;
    logic [9:0]       reg_num;
    logic [31:0]      data;
    logic             toggle;
    int               n_dw;
    logic [3:0][31:0] dw;
    logic             cpld;
    logic [2:0]       cpl_st;
    logic [31:0]      cpl_data;
    logic [31:0]      exp_rx;
  } vec_t;

  vec_t        vecs[4];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] got_dw[0:7];
  int          got_n;
  int          got_cycles;

  task automatic tick();
    @(posedge pclk_div2);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic start_req(input int v);
    pcie_cfg_fmt     = vecs[v].fmt;
    pcie_cfg_type    = vecs[v].typ;
    pcie_cfg_tag     = vecs[v].tag;
    pcie_cfg_fbe     = vecs[v].fbe;
    pcie_cfg_req_id  = vecs[v].req_id;
    pcie_cfg_des_id  = vecs[v].des_id;
    pcie_cfg_reg_num = vecs[v].reg_num;
    pcie_cfg_tx_data = vecs[v].data;
    tx_en = 1'b0;
    tick();
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    chk1("start_valid", cfg_tlp_tx_valid, 1'b1);
    chk1("start_sop", cfg_tlp_tx_sop, 1'b1);
  endtask

  task automatic collect(input logic toggle);
    logic        phase, held, done, hsop, heop;
    logic [31:0] hdata;
    int          cyc;
    phase = 1'b0; held = 1'b0; done = 1'b0; cyc = 0; got_n = 0;
    hsop = 1'b0; heop = 1'b0; hdata = 32'd0;
    while (!done && cyc < 40) begin
      if (held) begin
        chk("hold_data", cfg_tlp_tx_data, hdata);
        chk("hold_ctl", {29'd0, cfg_tlp_tx_valid, cfg_tlp_tx_sop, cfg_tlp_tx_eop},
            {29'd0, 1'b1, hsop, heop});
        held = 1'b0;
      end
      cfg_tlp_tx_ready = toggle ? phase : 1'b1;
      phase = ~phase;
      if (cfg_tlp_tx_valid) begin
        if (cfg_tlp_tx_ready) begin
          chk1("sop_pos", cfg_tlp_tx_sop, got_n == 0);
          if (got_n < 8) got_dw[got_n] = cfg_tlp_tx_data;
          got_n++;
          if (cfg_tlp_tx_eop) done = 1'b1;
        end else begin
          held = 1'b1;
          hdata = cfg_tlp_tx_data;
          hsop = cfg_tlp_tx_sop;
          heop = cfg_tlp_tx_eop;
        end
      end
      tick();
      cyc++;
    end
    got_cycles = cyc;
    cfg_tlp_tx_ready = 1'b1;
    if (!done) chk("tx_eop_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_tlp(input int v);
    chk("dw_count", got_n, vecs[v].n_dw);
    for (int i = 0; i < vecs[v].n_dw && i < got_n; i++)
      chk($sformatf("v%0d_dw%0d", v, i), got_dw[i], vecs[v].dw[i]);
  endtask

  task automatic send_cpl(input logic cpld, input logic [15:0] rid, input logic [7:0] tag,
                          input logic [2:0] st, input logic [31:0] d);
    cfg_tlp_rx_valid = 1'b1;
    cfg_tlp_rx_sop   = 1'b1;
    cfg_tlp_rx_eop   = 1'b0;
    cfg_tlp_rx_data  = {(cpld ? 3'b010 : 3'b000), 5'b01010, 14'd0, (cpld ? 10'd1 : 10'd0)};
    tick();
    cfg_tlp_rx_sop   = 1'b0;
    cfg_tlp_rx_data  = {16'h0200, st, 1'b0, 12'd4};
    tick();
    cfg_tlp_rx_data  = {rid, tag, 8'h00};
    cfg_tlp_rx_eop   = !cpld;
    tick();
    if (cpld) begin
      cfg_tlp_rx_data = d;
      cfg_tlp_rx_eop  = 1'b1;
      tick();
    end
    cfg_tlp_rx_valid = 1'b0;
    cfg_tlp_rx_eop   = 1'b0;
    cfg_tlp_rx_data  = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int early;
    vecs[0] = '{fmt:1'b0, typ:1'b0, tag:8'h05, fbe:4'hF, req_id:16'h0100, des_id:16'h0200,
                reg_num:10'h004, data:32'h0, toggle:1'b0, n_dw:3,
                dw:{32'h0, 32'h02000010, 32'h0100050F, 32'h04000001},
                cpld:1'b1, cpl_st:3'b000, cpl_data:32'hDEADBEEF, exp_rx:32'hDEADBEEF};
    vecs[1] = '{fmt:1'b1, typ:1'b1, tag:8'hA3, fbe:4'h3, req_id:16'h1234, des_id:16'h0A08,
                reg_num:10'h3C1, data:32'h12345678, toggle:1'b1, n_dw:4,
                dw:{32'h12345678, 32'h0A080F04, 32'h1234A303, 32'h45000001},
                cpld:1'b0, cpl_st:3'b001, cpl_data:32'h0, exp_rx:32'h0};
    vecs[2] = '{fmt:1'b0, typ:1'b1, tag:8'hFF, fbe:4'h1, req_id:16'hFFFF, des_id:16'hFFF8,
                reg_num:10'h3FF, data:32'h0, toggle:1'b0, n_dw:3,
                dw:{32'h0, 32'hFFF80FFC, 32'hFFFFFF01, 32'h05000001},
                cpld:1'b0, cpl_st:3'b100, cpl_data:32'h0, exp_rx:32'h0};
    vecs[3] = '{fmt:1'b1, typ:1'b0, tag:8'h00, fbe:4'hC, req_id:16'h0001, des_id:16'h0000,
                reg_num:10'h000, data:32'hA5A50F0F, toggle:1'b0, n_dw:4,
                dw:{32'hA5A50F0F, 32'h00000000, 32'h0001000C, 32'h44000001},
                cpld:1'b1, cpl_st:3'b010, cpl_data:32'hCAFE0001, exp_rx:32'hCAFE0001};

    tick();
    tick();
    chk1("rst_tx_valid", cfg_tlp_tx_valid, 1'b0);
    chk1("rst_sop", cfg_tlp_tx_sop, 1'b0);
    chk1("rst_eop", cfg_tlp_tx_eop, 1'b0);
    chk("rst_tx_data", cfg_tlp_tx_data, 32'd0);
    chk1("rst_busy", cfg_busy, 1'b0);
    chk1("rst_cpl_rcv", pcie_cfg_cpl_rcv, 1'b0);
    chk("rst_status", {29'd0, pcie_cfg_cpl_status}, 32'd0);
    chk("rst_rx_data", pcie_cfg_rx_data, 32'd0);
    apb_rst_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      start_req(v);
      collect(vecs[v].toggle);
      check_tlp(v);
      if (!vecs[v].toggle) chk("tx_latency", got_cycles, vecs[v].n_dw);
      chk1("wait_busy", cfg_busy, 1'b1);
      chk1("wait_no_pulse", pcie_cfg_cpl_rcv, 1'b0);
      send_cpl(vecs[v].cpld, vecs[v].req_id, vecs[v].tag, vecs[v].cpl_st, vecs[v].cpl_data);
      chk1("cpl_pulse", pcie_cfg_cpl_rcv, 1'b1);
      chk("cpl_status", {29'd0, pcie_cfg_cpl_status}, {29'd0, vecs[v].cpl_st});
      chk("cpl_rx_data", pcie_cfg_rx_data, vecs[v].exp_rx);
      chk1("cpl_busy_low", cfg_busy, 1'b0);
      tick();
      chk1("cpl_one_cycle", pcie_cfg_cpl_rcv, 1'b0);
      chk("cpl_data_held", pcie_cfg_rx_data, vecs[v].exp_rx);
    end

    // Wrong tag and wrong requester ID must both be dropped.
    start_req(0);
    collect(1'b0);
    send_cpl(1'b1, 16'h0100, 8'h06, 3'b000, 32'h11111111);
    chk1("wrong_tag_no_pulse", pcie_cfg_cpl_rcv, 1'b0);
    chk1("wrong_tag_busy", cfg_busy, 1'b1);
    send_cpl(1'b1, 16'h0101, 8'h05, 3'b000, 32'h33333333);
    chk1("wrong_rid_no_pulse", pcie_cfg_cpl_rcv, 1'b0);
    chk1("wrong_rid_busy", cfg_busy, 1'b1);
    send_cpl(1'b1, 16'h0100, 8'h05, 3'b000, 32'h22222222);
    chk1("right_tag_pulse", pcie_cfg_cpl_rcv, 1'b1);
    chk("right_tag_data", pcie_cfg_rx_data, 32'h22222222);
    tick();

    // Second edge while busy, then abort in WAIT_CPL.
    start_req(1);
    collect(1'b0);
    check_tlp(1);
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1("busy_edge_ignored", cfg_tlp_tx_valid, 1'b0);
      tick();
    end
    chk1("busy_still_wait", cfg_busy, 1'b1);
    pcie_cfg_ctrl_en = 1'b0;
    tick();
    chk1("abort_busy_low", cfg_busy, 1'b0);
    chk1("abort_no_pulse", pcie_cfg_cpl_rcv, 1'b0);
    send_cpl(1'b0, 16'h1234, 8'hA3, 3'b000, 32'h0);
    chk1("late_cpl_no_pulse", pcie_cfg_cpl_rcv, 1'b0);
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    tick();
    chk1("disabled_edge_ignored", cfg_tlp_tx_valid, 1'b0);
    pcie_cfg_ctrl_en = 1'b1;
    tick();

    // ctrl_en dropped mid-TLP: stream completes, then idle.
    start_req(1);
    pcie_cfg_ctrl_en = 1'b0;
    collect(1'b0);
    check_tlp(1);
    chk1("tx_abort_idle", cfg_busy, 1'b0);
    pcie_cfg_ctrl_en = 1'b1;
    tick();
    chk1("tx_abort_stays_idle", cfg_busy, 1'b0);

    // Reset during TX_H1.
    start_req(0);
    tick();
    chk("h1_before_reset", cfg_tlp_tx_data, vecs[0].dw[1]);
    apb_rst_n = 1'b0;
    #1;
    chk1("reset_valid_low", cfg_tlp_tx_valid, 1'b0);
    chk1("reset_busy_low", cfg_busy, 1'b0);
    tick();
    apb_rst_n = 1'b1;
    tick();
    chk1("no_resume", cfg_tlp_tx_valid, 1'b0);
    start_req(0);
    collect(1'b0);
    check_tlp(0);
    send_cpl(1'b1, 16'h0100, 8'h05, 3'b000, 32'hDEADBEEF);
    chk1("post_reset_pulse", pcie_cfg_cpl_rcv, 1'b1);
    chk("post_reset_data", pcie_cfg_rx_data, 32'hDEADBEEF);
    tick();

`ifdef PCIE_CFG_CPL_TIMEOUT_EN
    start_req(0);
    collect(1'b0);
    early = 0;
    for (int k = 1; k < 16; k++) begin
      if (pcie_cfg_cpl_rcv) early++;
      tick();
    end
    chk("timeout_early_pulse", early, 0);
    chk1("timeout_not_yet", pcie_cfg_cpl_rcv, 1'b0);
    tick();
    chk1("timeout_pulse", pcie_cfg_cpl_rcv, 1'b1);
    chk("timeout_status", {29'd0, pcie_cfg_cpl_status}, 32'd7);
    chk("timeout_data", pcie_cfg_rx_data, 32'd0);
    chk1("timeout_busy", cfg_busy, 1'b0);
`else
    early = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
